// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory and decode handshake bundle for mips_fetch_unit.
// master = fetch unit side, slave = memory/decode side.
interface mips_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// Decoupled MIPS fetch front end: in-order imem requests, DEPTH-entry PC/word queue, redirect and halt.
// Optional misaligned-redirect fault: define MIPS_FETCH_ALIGN_CHECK_EN.
module mips_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_b,
  mips_fetch_unit_if.master bus,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt_req,
  output logic              halted,
  output logic              fault
);

  localparam int                PW         = $clog2(DEPTH);
  localparam int                CW         = PW + 1;
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_W / 8 - 1);

  logic [ADDR_W-1:0] fetch_pc, rsp_pc;
  logic [INST_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, outstanding, discard;
  logic              halt_pend;

  logic [CW+1:0]     credit_used;
  logic              req_valid, req_fire, rsp_live, pop, redir, misaligned;
  logic [ADDR_W-1:0] target_eff;
  logic [CW-1:0]     out_next, disc_next;
  logic              halt_pend_next;

  // Every in-flight request (live or stale) and buffered word holds one credit.
  always_comb begin
    credit_used    = (CW+2)'(outstanding) + (CW+2)'(discard) + (CW+2)'(count);
    req_valid      = rst_b && !halt_pend && !halted && (credit_used < (CW+2)'(DEPTH));
    req_fire       = req_valid && bus.imem_req_ready;
    rsp_live       = bus.imem_rsp_valid && (discard == '0);
    pop            = (count != '0) && bus.inst_ready;
    redir          = redirect_valid && !halted;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    misaligned     = (redirect_target & ALIGN_MASK) != '0;
`else
    misaligned     = 1'b0;
`endif
    target_eff     = redirect_target & ~ALIGN_MASK;
    halt_pend_next = halt_pend || halt_req || (redir && misaligned);
    if (redir) begin
      out_next  = '0;
      disc_next = discard + outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    end else begin
      out_next  = outstanding + CW'(req_fire) - CW'(rsp_live);
      disc_next = discard - CW'(bus.imem_rsp_valid && !rsp_live);
    end
  end

  always_comb begin
    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = fetch_pc;
    bus.inst_valid     = count != '0;
    bus.inst_data      = q_data[rd_ptr];
    bus.inst_pc        = q_pc[rd_ptr];
  end

  // A redirect flushes the queue and voids any same-cycle pop or live write.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      halt_pend   <= 1'b0;
      halted      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      outstanding <= out_next;
      discard     <= disc_next;
      halt_pend   <= halt_pend_next;
      if (halt_pend_next && (out_next == '0) && (disc_next == '0))
        halted <= 1'b1;
      if (redir) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        if (!misaligned) begin
          fetch_pc <= target_eff;
          rsp_pc   <= target_eff;
        end
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + STEP;
        if (rsp_live) begin
          q_data[wr_ptr] <= bus.imem_rsp_data;
          q_pc[wr_ptr]   <= rsp_pc;
          wr_ptr         <= wr_ptr + PW'(1);
          rsp_pc         <= rsp_pc + STEP;
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(rsp_live) - CW'(pop);
      end
    end
  end

`ifdef MIPS_FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      fault <= 1'b0;
    else if (redir && misaligned)
      fault <= 1'b1;
  end
`else
  always_comb fault = 1'b0;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized scoreboard bench for mips_fetch_unit: program-order PC stream model plus in-order memory model.
// Build with MIPS_FETCH_ALIGN_CHECK_EN defined to exercise the misaligned-redirect fault path.
module tb_mips_fetch_unit;
  localparam int          ADDR_W   = 32;
  localparam int          INST_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        halt_req = 1'b0;
  logic        halted, fault;

  always #5 clk = ~clk;

  mips_fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  mips_fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_b(rst_b), .bus(bus),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .halted(halted), .fault(fault)
  );

  typedef struct { logic [31:0] addr; int due; } mem_t;

  int          vectors = 0, miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  mem_t        mem_q[$];
  int          cyc;
  bit          mhalt_pend, mhalted, mfault;
  bit          redir_chk, redir_addr_chk, run_monitor;
  logic [31:0] redir_addr;
  int          mem_ready_pct, inst_ready_pct, redir_pct, max_lat;
  bit          force_redir, force_halt;
  logic [31:0] force_target;
  int          acc_count, pop_count;
  logic        s_req_valid, s_inst_valid, s_halted, s_fault;
  logic [31:0] s_req_addr, s_inst_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic driveInputs();
    bus.imem_req_ready = ($urandom_range(99) < mem_ready_pct);
    bus.inst_ready     = ($urandom_range(99) < inst_ready_pct);
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    if (force_redir) begin
      redirect_valid  = 1'b1;
      redirect_target = force_target;
      force_redir     = 1'b0;
    end else if ($urandom_range(99) < redir_pct) begin
      redirect_valid  = 1'b1;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
      redirect_target = $urandom & 32'h0000_FFFC;
`else
      redirect_target = $urandom & 32'h0000_FFFF;
`endif
    end else begin
      redirect_valid  = 1'b0;
      redirect_target = $urandom;
    end
    halt_req   = force_halt;
    force_halt = 1'b0;
  endtask

  // One call = n clock cycles: sample at negedge, update models after the edge, drive next inputs.
  task automatic applyStimulus(input int n);
    bit          acc, rfire, rd, hr;
    logic [31:0] acc_addr, rt;
    mem_t        m;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc          = bus.imem_req_valid && bus.imem_req_ready;
      acc_addr     = bus.imem_req_addr;
      rfire        = bus.imem_rsp_valid;
      rd           = redirect_valid;
      rt           = redirect_target;
      hr           = halt_req;
      s_req_valid  = bus.imem_req_valid;
      s_req_addr   = bus.imem_req_addr;
      s_inst_valid = bus.inst_valid;
      s_inst_pc    = bus.inst_pc;
      s_halted     = halted;
      s_fault      = fault;
      if (acc) acc_count++;
      if (bus.inst_valid && bus.inst_ready) pop_count++;
      @(posedge clk);
      #1;
      cyc++;
      if (rfire) void'(mem_q.pop_front());
      if (acc) begin
        m.addr = acc_addr;
        m.due  = cyc - 1 + $urandom_range(max_lat, 1);
        mem_q.push_back(m);
      end
      redir_chk = 1'b0;
      if (rd && !mhalted) begin
        exp_q.delete();
        redir_chk = 1'b1;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
        if ((rt & 32'h3) != 0) begin
          mfault         = 1'b1;
          mhalt_pend     = 1'b1;
          redir_addr_chk = 1'b0;
        end else begin
          gen_pc         = rt;
          redir_addr     = rt;
          redir_addr_chk = 1'b1;
        end
`else
        gen_pc         = rt & 32'hFFFF_FFFC;
        redir_addr     = gen_pc;
        redir_addr_chk = 1'b1;
`endif
      end
      if (hr) mhalt_pend = 1'b1;
      if (mhalt_pend && mem_q.size() == 0) mhalted = 1'b1;
      exp_q.push_back(gen_pc);
      gen_pc += 32'd4;
      driveInputs();
    end
  endtask

  task automatic doReset();
    run_monitor = 1'b0;
    rst_b = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req_valid", bus.imem_req_valid, 0);
    checkOutput("rst_req_addr", bus.imem_req_addr, RESET_PC);
    checkOutput("rst_inst_valid", bus.inst_valid, 0);
    checkOutput("rst_inst_data", bus.inst_data, 0);
    checkOutput("rst_inst_pc", bus.inst_pc, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_fault", fault, 0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    exp_q.delete();
    mem_q.delete();
    exp_q.push_back(RESET_PC);
    gen_pc = RESET_PC + 32'd4;
    cyc = 0;
    mhalt_pend = 0; mhalted = 0; mfault = 0;
    redir_chk = 0; redir_addr_chk = 0;
    force_redir = 0; force_halt = 0;
    acc_count = 0; pop_count = 0;
    driveInputs();
    run_monitor = 1'b1;
  endtask

  // Scoreboard monitor: compares every accepted decode word against the model stream.
  always @(negedge clk) begin
    logic [31:0] e;
    if (run_monitor) begin
      if (redir_chk) begin
        checkOutput("redirect_inst_valid", bus.inst_valid, 0);
        if (redir_addr_chk) checkOutput("redirect_req_addr", bus.imem_req_addr, redir_addr);
      end
      checkOutput("halted", halted, mhalted);
      checkOutput("fault", fault, mfault);
      if (mhalt_pend || mhalted) checkOutput("halt_no_req", bus.imem_req_valid, 0);
      if (bus.inst_valid && bus.inst_ready && !(redirect_valid && !mhalted)) begin
        if (exp_q.size() == 0) begin
          checkOutput("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("inst_pc", bus.inst_pc, e);
          checkOutput("inst_data", bus.inst_data, mem_word(e));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    mem_ready_pct = 100; inst_ready_pct = 0; redir_pct = 0; max_lat = 1;
    force_redir = 0; force_halt = 0; force_target = '0;
    doReset();

    // Start-up latency and back-pressure fill.
    applyStimulus(1);
    checkOutput("first_req_valid", s_req_valid, 1);
    checkOutput("first_req_addr", s_req_addr, RESET_PC);
    applyStimulus(1);
    checkOutput("inst_valid_cycle1", s_inst_valid, 0);
    applyStimulus(1);
    checkOutput("inst_valid_cycle2", s_inst_valid, 1);
    checkOutput("inst_pc_cycle2", s_inst_pc, RESET_PC);
    applyStimulus(7);
    checkOutput("fill_req_count", acc_count, DEPTH);
    checkOutput("fill_req_valid", s_req_valid, 0);

    // Full throughput with single-cycle memory.
    inst_ready_pct = 100;
    applyStimulus(5);
    pop_count = 0;
    applyStimulus(20);
    checkOutput("throughput_pops", pop_count, 20);

    // Random traffic with redirects.
    mem_ready_pct = 70; inst_ready_pct = 70; redir_pct = 4; max_lat = 3;
    applyStimulus(1500);

    // Halt and drain; later redirects must be ignored.
    redir_pct = 0;
    force_halt = 1'b1;
    n = 0;
    while (!mhalted && n < 200) begin
      applyStimulus(1);
      n++;
    end
    if (!mhalted) checkOutput("halt_timeout", 0, 1);
    mem_ready_pct = 100; inst_ready_pct = 100; redir_pct = 50;
    applyStimulus(12);
    checkOutput("halted_drained_valid", s_inst_valid, 0);
    checkOutput("halted_req_valid", s_req_valid, 0);
    checkOutput("halted_sticky", s_halted, 1);

    // Misaligned redirect target.
    redir_pct = 0; max_lat = 1;
    doReset();
    applyStimulus(20);
    force_redir = 1'b1;
    force_target = 32'h0000_0102;
    applyStimulus(2);
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    n = 0;
    while (!mhalted && n < 50) begin
      applyStimulus(1);
      n++;
    end
    if (!mhalted) checkOutput("fault_halt_timeout", 0, 1);
    applyStimulus(2);
    checkOutput("fault_flag", s_fault, 1);
    checkOutput("fault_halted", s_halted, 1);
`else
    pop_count = 0;
    applyStimulus(10);
    checkOutput("post_redirect_pops", pop_count != 0, 1);
    checkOutput("no_fault", s_fault, 0);
`endif

    run_monitor = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
